sm83_stack_engine: RTL and testbench
====================================

// Module: sm83_stack_engine
// PURPOSE
//  Executes PUSH/POP of a 16-bit value (BC, DE, HL, AF, PC) between the register file and the byte-wide memory bus.
//  Sits beside the register file: reads its ports, drives byte accesses at SP, then returns results through the wen/w_* write ports.
//  Latches operands at accept. Commits SP and the target only when the access sequence completes.
// PARAMETERS
//  PUSH_PRE_DELAY  1  internal idle cycles before the first push write (SM83 internal M-cycle); 0 allowed
// PORTS
//  clk        in   1   core clock; all state on posedge
//  rst_n      in   1   asynchronous active-low reset
//  req_valid  in   1   operation request
//  req_ready  out  1   1 only in IDLE; accept = req_valid & req_ready
//  req_pop    in   1   0=PUSH, 1=POP
//  req_tgt    in   3   0=BC 1=DE 2=HL 3=AF 4=PC; 5-7 illegal
//  rf_sel16   out  2   gp16 select (read and write); IDLE: req_tgt[1:0], else latched target
//  rf_r16     in   16  register file gp16 read data
//  rf_a       in   8   A
//  rf_f       in   4   flags {Z,N,H,C}
//  rf_pc      in   16  PC
//  rf_sp      in   16  SP
//  wen_gp16   out  1   gp16 write strobe; w16 out 16 data
//  wen_a      out  1   A write strobe; w_a out 8 data
//  wen_f      out  1   F write strobe; w_f out 4 data
//  wen_pc     out  1   PC write strobe; w_pc out 16 data
//  wen_sp     out  1   SP write strobe; w_sp out 16 data
//  mem_req    out  1   bus request, held until mem_ack
//  mem_we     out  1   1=write
//  mem_addr   out  16  byte address
//  mem_wdata  out  8   write byte
//  mem_ack    in   1   completes current access; ignored when mem_req=0; same-cycle ack legal
//  mem_rdata  in   8   read byte, valid with mem_ack
//  done       out  1   one-cycle completion pulse
//  err        out  1   one-cycle pulse with done for illegal target
// BEHAVIOUR
//  Reset: IDLE. All outputs 0 except req_ready=1. Reset mid-operation aborts with no writeback; completed bus writes stand.
//  On accept, latch SP, op and target. PUSH also latches data: gp16, {A,F,4'b0} or PC.
//  States: IDLE, PRE, WR_HI, WR_LO, RD_LO, RD_HI, FIN, ERR.
//  IDLE->ERR (tgt>4) ; ->PRE (push, DELAY>0) ; ->WR_HI (push, DELAY=0) ; ->RD_LO (pop).
//  PRE: count DELAY cycles, no bus activity, then ->WR_HI.
//  WR_HI: write addr=SP-1, data=hi byte. On ack ->WR_LO.
//  WR_LO: write addr=SP-2, data=lo byte. On ack ->FIN.
//  RD_LO: read addr=SP. On ack latch lo ->RD_HI.
//  RD_HI: read addr=SP+1. On ack latch hi ->FIN.
//  FIN (1 cycle): done=1, wen_sp=1. Push w_sp=SP-2; pop w_sp=SP+2.
//  FIN pop writeback: target strobe with {hi,lo}. AF: w_a=hi, w_f=lo[7:4], lo[3:0] discarded. Then ->IDLE.
//  ERR (1 cycle): done=1, err=1, no bus access, no wen. Then ->IDLE.
//  mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and not acked.
//  mem_req deasserts in the cycle after the ack unless the next access follows.
//  Address/SP arithmetic is mod 2^16 (wraps 0x0000<->0xFFFF).
//  wen_* and w_* are 0 outside FIN. Changes on the rf_* inputs after accept have no effect.
//  Zero-wait latency (accept=c0): push DELAY=1 done c4; push DELAY=0 done c3; pop done c3; illegal done c1.
// TESTING
//  Push BC=0x1234, SP=0xFFFE, zero-wait -> wr 0xFFFD=0x12, 0xFFFC=0x34; w_sp=0xFFFC; done c4.
//  Pop AF, SP=0xC000, mem C000=0xF7, C001=0x5A -> w_a=0x5A, w_f=0xF, w_sp=0xC002, done c3.
//  Push PC=0xABCD, SP=0x0001 -> wr 0x0000=0xAB, 0xFFFF=0xCD, w_sp=0xFFFF. Pop it back -> w_pc=0xABCD, w_sp=0x0001.
//  Push DE with 3-cycle ack delay per access -> addr/wdata stable while waiting, no early wen; done c10.
//  Push HL; change rf_r16/rf_sp mid-op -> memory and w_sp reflect accept-time values.
//  rst_n low during WR_LO -> mem_req=0 and no wen at once; req_ready=1 after release. tgt=5 -> done+err c1, no mem_req.

Source files
------------

// File: rtl/sm83_stack_engine.sv
// sm83_stack_engine
// Runs PUSH/POP of a 16-bit register (BC, DE, HL, AF, PC) between the register
// file and a byte-wide memory bus. Operands are latched at accept. SP and the
// target register are written back only in the single FIN cycle.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready/req_pop/req_tgt   operation request handshake
//   rf_sel16                        gp16 select (read in IDLE, write in FIN)
//   rf_r16, rf_a, rf_f, rf_pc, rf_sp     register file read ports
//   wen_*/w_*                       register file write ports (FIN only)
//   mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata   byte bus
//   done, err                       completion pulse, illegal-target pulse
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a request, req_ready=1
// PRE    | push internal delay, counts PUSH_PRE_DELAY cycles, no bus
// WR_HI  | write high byte at SP-1
// WR_LO  | write low byte at SP-2
// RD_LO  | read low byte at SP
// RD_HI  | read high byte at SP+1
// FIN    | one cycle: done, SP writeback, pop target writeback
// ERR    | one cycle: done+err for target codes 5..7

module sm83_stack_engine #(
   parameter int PUSH_PRE_DELAY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_pop,
   input  logic [2:0]  req_tgt,
   output logic [1:0]  rf_sel16,
   input  logic [15:0] rf_r16,
   input  logic [7:0]  rf_a,
   input  logic [3:0]  rf_f,
   input  logic [15:0] rf_pc,
   input  logic [15:0] rf_sp,
   output logic        wen_gp16,
   output logic [15:0] w16,
   output logic        wen_a,
   output logic [7:0]  w_a,
   output logic        wen_f,
   output logic [3:0]  w_f,
   output logic        wen_pc,
   output logic [15:0] w_pc,
   output logic        wen_sp,
   output logic [15:0] w_sp,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic        mem_ack,
   input  logic [7:0]  mem_rdata,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE, S_PRE, S_WR_HI, S_WR_LO, S_RD_LO, S_RD_HI, S_FIN, S_ERR
   } state_t;

   localparam int CW = (PUSH_PRE_DELAY > 1) ? $clog2(PUSH_PRE_DELAY + 1) : 1;
   localparam logic [CW-1:0] PRE_LOAD = CW'(PUSH_PRE_DELAY);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [2:0]    T_AF     = 3'd3;
   localparam logic [2:0]    T_PC     = 3'd4;

   state_t        state_q, state_d;
   logic [15:0]   sp_q;
   logic [15:0]   data_q;
   logic [2:0]    tgt_q;
   logic          pop_q;
   logic [CW-1:0] cnt_q;
   logic          accept;
   logic [15:0]   push_data;

   assign accept = req_valid && (state_q == S_IDLE);

   always_comb begin
      push_data = rf_r16;
      case (req_tgt)
         T_AF:    push_data = {rf_a, rf_f, 4'b0000};
         T_PC:    push_data = rf_pc;
         default: push_data = rf_r16;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (req_tgt > T_PC)          state_d = S_ERR;
               else if (req_pop)            state_d = S_RD_LO;
               else if (PUSH_PRE_DELAY > 0) state_d = S_PRE;
               else                         state_d = S_WR_HI;
            end
         end
         S_PRE:   if (cnt_q <= CNT_ONE) state_d = S_WR_HI;
         S_WR_HI: if (mem_ack) state_d = S_WR_LO;
         S_WR_LO: if (mem_ack) state_d = S_FIN;
         S_RD_LO: if (mem_ack) state_d = S_RD_HI;
         S_RD_HI: if (mem_ack) state_d = S_FIN;
         S_FIN:   state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Operand latches; data_q holds the push value or assembles the popped word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp_q   <= 16'h0000;
         data_q <= 16'h0000;
         tgt_q  <= 3'd0;
         pop_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  sp_q   <= rf_sp;
                  data_q <= push_data;
                  tgt_q  <= req_tgt;
                  pop_q  <= req_pop;
                  cnt_q  <= PRE_LOAD;
               end
            end
            S_PRE:   cnt_q <= cnt_q - CNT_ONE;
            S_RD_LO: if (mem_ack) data_q[7:0]  <= mem_rdata;
            S_RD_HI: if (mem_ack) data_q[15:8] <= mem_rdata;
            default: ;
         endcase
      end
   end

   always_comb begin
      req_ready = 1'b0;
      rf_sel16  = tgt_q[1:0];
      wen_gp16  = 1'b0;
      w16       = 16'h0000;
      wen_a     = 1'b0;
      w_a       = 8'h00;
      wen_f     = 1'b0;
      w_f       = 4'h0;
      wen_pc    = 1'b0;
      w_pc      = 16'h0000;
      wen_sp    = 1'b0;
      w_sp      = 16'h0000;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 16'h0000;
      mem_wdata = 8'h00;
      done      = 1'b0;
      err       = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            rf_sel16  = req_tgt[1:0];
         end
         S_WR_HI: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = sp_q - 16'd1;
            mem_wdata = data_q[15:8];
         end
         S_WR_LO: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = sp_q - 16'd2;
            mem_wdata = data_q[7:0];
         end
         S_RD_LO: begin
            mem_req  = 1'b1;
            mem_addr = sp_q;
         end
         S_RD_HI: begin
            mem_req  = 1'b1;
            mem_addr = sp_q + 16'd1;
         end
         S_FIN: begin
            done   = 1'b1;
            wen_sp = 1'b1;
            w_sp   = pop_q ? (sp_q + 16'd2) : (sp_q - 16'd2);
            if (pop_q) begin
               case (tgt_q)
                  T_AF: begin
                     // Low nibble of the popped F byte does not exist in hardware.
                     wen_a = 1'b1;
                     w_a   = data_q[15:8];
                     wen_f = 1'b1;
                     w_f   = data_q[7:4];
                  end
                  T_PC: begin
                     wen_pc = 1'b1;
                     w_pc   = data_q;
                  end
                  default: begin
                     wen_gp16 = 1'b1;
                     w16      = data_q;
                  end
               endcase
            end
         end
         S_ERR: begin
            done = 1'b1;
            err  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_sm83_stack_engine.sv
module tb_sm83_stack_engine;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_pop;
   logic [2:0]  req_tgt;
   logic [1:0]  rf_sel16;
   logic [15:0] rf_r16, rf_pc, rf_sp;
   logic [7:0]  rf_a;
   logic [3:0]  rf_f;
   logic        wen_gp16, wen_a, wen_f, wen_pc, wen_sp;
   logic [15:0] w16, w_pc, w_sp;
   logic [7:0]  w_a;
   logic [3:0]  w_f;
   logic        mem_req, mem_we, mem_ack;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;
   logic        done, err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sm83_stack_engine #(.PUSH_PRE_DELAY(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_pop(req_pop), .req_tgt(req_tgt),
      .rf_sel16(rf_sel16), .rf_r16(rf_r16), .rf_a(rf_a), .rf_f(rf_f), .rf_pc(rf_pc), .rf_sp(rf_sp),
      .wen_gp16(wen_gp16), .w16(w16), .wen_a(wen_a), .w_a(w_a), .wen_f(wen_f), .w_f(w_f),
      .wen_pc(wen_pc), .w_pc(w_pc), .wen_sp(wen_sp), .w_sp(w_sp),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .done(done), .err(err)
   );

   // Memory model with programmable wait states per access.
   logic [7:0]  mem [0:65535];
   int          ack_lat = 0;
   int          wcnt = 0;
   logic [15:0] wl_a[$];
   logic [7:0]  wl_d[$];

   assign mem_ack   = mem_req && (wcnt >= ack_lat);
   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (mem_req && !mem_ack) wcnt <= wcnt + 1;
      else                     wcnt <= 0;
      if (mem_req && mem_ack && mem_we) begin
         mem[mem_addr] = mem_wdata;
         wl_a.push_back(mem_addr);
         wl_d.push_back(mem_wdata);
      end
   end

   // Captured at the done cycle
   logic        c_wen_gp16, c_wen_a, c_wen_f, c_wen_pc, c_wen_sp, c_err;
   logic [15:0] c_w16, c_w_pc, c_w_sp;
   logic [7:0]  c_w_a;
   logic [3:0]  c_w_f;
   logic [1:0]  c_sel;
   int          nreq;
   logic        early_wen, unstable;

   // Issues one request and observes until done; cyc = done cycle or -1 on timeout.
   task automatic run_op(input logic pop, input logic [2:0] tgt, output int cyc);
      logic        p_wait;
      logic [15:0] p_addr;
      logic [7:0]  p_wd;
      logic        p_we;
      wl_a.delete();
      wl_d.delete();
      nreq = 0; early_wen = 0; unstable = 0; p_wait = 0;
      p_addr = 0; p_wd = 0; p_we = 0;
      cyc = -1;
      @(negedge clk);
      req_valid = 1'b1; req_pop = pop; req_tgt = tgt;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (mem_req) nreq++;
         if (!done && (wen_gp16 || wen_a || wen_f || wen_pc || wen_sp)) early_wen = 1;
         if (p_wait && (mem_addr !== p_addr || mem_wdata !== p_wd || mem_we !== p_we)) unstable = 1;
         p_wait = mem_req && !mem_ack;
         p_addr = mem_addr; p_wd = mem_wdata; p_we = mem_we;
         if (done) begin
            c_wen_gp16 = wen_gp16; c_w16 = w16; c_wen_a = wen_a; c_w_a = w_a;
            c_wen_f = wen_f; c_w_f = w_f; c_wen_pc = wen_pc; c_w_pc = w_pc;
            c_wen_sp = wen_sp; c_w_sp = w_sp; c_err = err; c_sel = rf_sel16;
            cyc = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      req_tgt = 3'd2;
      #1;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", req_ready); end
      total++; if ({mem_req, mem_we, done, err} !== 4'b0000) begin bad++; $display("FAIL reset_ctrl got=%b want=0000", {mem_req, mem_we, done, err}); end
      total++; if ({wen_gp16, wen_a, wen_f, wen_pc, wen_sp} !== 5'b0) begin bad++; $display("FAIL reset_wen got=%b want=00000", {wen_gp16, wen_a, wen_f, wen_pc, wen_sp}); end
      total++; if (rf_sel16 !== 2'd2) begin bad++; $display("FAIL idle_sel got=%0d want=2", rf_sel16); end
   endtask

   task automatic test_push_bc();
      int cyc;
      ack_lat = 0; rf_r16 = 16'h1234; rf_sp = 16'hFFFE;
      run_op(1'b0, 3'd0, cyc);
      total++; if (cyc !== 4) begin bad++; $display("FAIL push_bc_latency got=%0d want=4", cyc); end
      total++; if (wl_a.size() !== 2) begin bad++; $display("FAIL push_bc_nwr got=%0d want=2", wl_a.size()); end
      total++; if ({wl_a[0], wl_d[0], wl_a[1], wl_d[1]} !== {16'hFFFD, 8'h12, 16'hFFFC, 8'h34})
         begin bad++; $display("FAIL push_bc_writes got=%h/%h %h/%h want=fffd/12 fffc/34", wl_a[0], wl_d[0], wl_a[1], wl_d[1]); end
      total++; if ({c_wen_sp, c_w_sp} !== {1'b1, 16'hFFFC}) begin bad++; $display("FAIL push_bc_sp got=%b/%h want=1/fffc", c_wen_sp, c_w_sp); end
      total++; if ({c_wen_gp16, c_wen_a, c_wen_f, c_wen_pc, c_err} !== 5'b0) begin bad++; $display("FAIL push_bc_nowb got=%b want=00000", {c_wen_gp16, c_wen_a, c_wen_f, c_wen_pc, c_err}); end
   endtask

   task automatic test_pop_af();
      int cyc;
      ack_lat = 0; rf_sp = 16'hC000;
      mem[16'hC000] = 8'hF7; mem[16'hC001] = 8'h5A;
      run_op(1'b1, 3'd3, cyc);
      total++; if (cyc !== 3) begin bad++; $display("FAIL pop_af_latency got=%0d want=3", cyc); end
      total++; if ({c_wen_a, c_w_a, c_wen_f, c_w_f} !== {1'b1, 8'h5A, 1'b1, 4'hF})
         begin bad++; $display("FAIL pop_af_wb got=%b/%h %b/%h want=1/5a 1/f", c_wen_a, c_w_a, c_wen_f, c_w_f); end
      total++; if ({c_wen_sp, c_w_sp, c_wen_gp16, c_wen_pc} !== {1'b1, 16'hC002, 2'b00})
         begin bad++; $display("FAIL pop_af_sp got=%b/%h gp=%b pc=%b want=1/c002 0 0", c_wen_sp, c_w_sp, c_wen_gp16, c_wen_pc); end
      total++; if (wl_a.size() !== 0) begin bad++; $display("FAIL pop_af_nowrite got=%0d want=0", wl_a.size()); end
   endtask

   task automatic test_wrap_pc();
      int cyc;
      ack_lat = 0; rf_pc = 16'hABCD; rf_sp = 16'h0001;
      run_op(1'b0, 3'd4, cyc);
      total++; if ({wl_a[0], wl_d[0], wl_a[1], wl_d[1]} !== {16'h0000, 8'hAB, 16'hFFFF, 8'hCD})
         begin bad++; $display("FAIL wrap_push_writes got=%h/%h %h/%h want=0000/ab ffff/cd", wl_a[0], wl_d[0], wl_a[1], wl_d[1]); end
      total++; if (c_w_sp !== 16'hFFFF) begin bad++; $display("FAIL wrap_push_sp got=%h want=ffff", c_w_sp); end
      rf_pc = 16'h0000; rf_sp = 16'hFFFF;
      run_op(1'b1, 3'd4, cyc);
      total++; if ({c_wen_pc, c_w_pc} !== {1'b1, 16'hABCD}) begin bad++; $display("FAIL wrap_pop_pc got=%b/%h want=1/abcd", c_wen_pc, c_w_pc); end
      total++; if (c_w_sp !== 16'h0001) begin bad++; $display("FAIL wrap_pop_sp got=%h want=0001", c_w_sp); end
   endtask

   task automatic test_wait_states();
      int cyc;
      ack_lat = 3; rf_r16 = 16'hBEEF; rf_sp = 16'h8000;
      run_op(1'b0, 3'd1, cyc);
      total++; if (cyc !== 10) begin bad++; $display("FAIL wait_latency got=%0d want=10", cyc); end
      total++; if (unstable !== 1'b0) begin bad++; $display("FAIL wait_stable got=%b want=0", unstable); end
      total++; if (early_wen !== 1'b0) begin bad++; $display("FAIL wait_early_wen got=%b want=0", early_wen); end
      total++; if (nreq !== 8) begin bad++; $display("FAIL wait_req_cycles got=%0d want=8", nreq); end
      total++; if ({wl_a[0], wl_d[0], wl_a[1], wl_d[1]} !== {16'h7FFF, 8'hBE, 16'h7FFE, 8'hEF})
         begin bad++; $display("FAIL wait_writes got=%h/%h %h/%h want=7fff/be 7ffe/ef", wl_a[0], wl_d[0], wl_a[1], wl_d[1]); end
      ack_lat = 0;
   endtask

   task automatic test_operand_latch();
      int cyc;
      ack_lat = 1; rf_r16 = 16'h5566; rf_sp = 16'h9000;
      fork
         run_op(1'b0, 3'd2, cyc);
         begin
            @(posedge req_valid);
            @(posedge clk);
            #2 rf_r16 = 16'h0000; rf_sp = 16'h1111;
         end
      join
      total++; if ({wl_a[0], wl_d[0], wl_a[1], wl_d[1]} !== {16'h8FFF, 8'h55, 16'h8FFE, 8'h66})
         begin bad++; $display("FAIL latch_writes got=%h/%h %h/%h want=8fff/55 8ffe/66", wl_a[0], wl_d[0], wl_a[1], wl_d[1]); end
      total++; if (c_w_sp !== 16'h8FFE) begin bad++; $display("FAIL latch_sp got=%h want=8ffe", c_w_sp); end
      ack_lat = 0;
   endtask

   task automatic test_pop_de();
      int cyc;
      ack_lat = 0; rf_sp = 16'h4000; rf_r16 = 16'h0000;
      mem[16'h4000] = 8'h78; mem[16'h4001] = 8'h9A;
      run_op(1'b1, 3'd1, cyc);
      total++; if ({c_wen_gp16, c_w16, c_sel} !== {1'b1, 16'h9A78, 2'd1})
         begin bad++; $display("FAIL pop_de_wb got=%b/%h sel=%0d want=1/9a78 sel=1", c_wen_gp16, c_w16, c_sel); end
      total++; if ({c_wen_a, c_wen_f, c_wen_pc} !== 3'b000) begin bad++; $display("FAIL pop_de_other got=%b want=000", {c_wen_a, c_wen_f, c_wen_pc}); end
   endtask

   task automatic test_back_to_back_af();
      int cyc;
      ack_lat = 0; rf_a = 8'h3C; rf_f = 4'hA; rf_sp = 16'hD000;
      run_op(1'b0, 3'd3, cyc);
      total++; if ({wl_a[0], wl_d[0], wl_a[1], wl_d[1]} !== {16'hCFFF, 8'h3C, 16'hCFFE, 8'hA0})
         begin bad++; $display("FAIL push_af_writes got=%h/%h %h/%h want=cfff/3c cffe/a0", wl_a[0], wl_d[0], wl_a[1], wl_d[1]); end
      rf_a = 8'h00; rf_f = 4'h0; rf_sp = 16'hCFFE;
      run_op(1'b1, 3'd3, cyc);
      total++; if ({c_w_a, c_w_f, c_w_sp} !== {8'h3C, 4'hA, 16'hD000})
         begin bad++; $display("FAIL pop_af_roundtrip got=%h/%h/%h want=3c/a/d000", c_w_a, c_w_f, c_w_sp); end
   endtask

   task automatic test_illegal();
      int cyc;
      run_op(1'b0, 3'd5, cyc);
      total++; if ({cyc == 1, c_err} !== 2'b11) begin bad++; $display("FAIL illegal5 cyc=%0d err=%b want cyc=1 err=1", cyc, c_err); end
      total++; if ({nreq, c_wen_sp} !== {32'd0, 1'b0}) begin bad++; $display("FAIL illegal5_side got req=%0d wen_sp=%b want 0 0", nreq, c_wen_sp); end
      run_op(1'b1, 3'd7, cyc);
      total++; if ({cyc == 1, c_err, nreq == 0} !== 3'b111) begin bad++; $display("FAIL illegal7 cyc=%0d err=%b req=%0d want 1 1 0", cyc, c_err, nreq); end
   endtask

   task automatic test_reset_mid();
      logic hit;
      ack_lat = 5; rf_r16 = 16'h7788; rf_sp = 16'h2000; hit = 0;
      wl_a.delete(); wl_d.delete();
      @(negedge clk);
      req_valid = 1'b1; req_pop = 1'b0; req_tgt = 3'd0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (mem_req && mem_addr == 16'h1FFE) begin hit = 1; break; end
      end
      total++; if (hit !== 1'b1) begin bad++; $display("FAIL rst_mid_reach got=%b want=1", hit); end
      rst_n = 1'b0;
      #1;
      total++; if ({mem_req, wen_sp, wen_gp16, done} !== 4'b0000) begin bad++; $display("FAIL rst_mid_abort got=%b want=0000", {mem_req, wen_sp, wen_gp16, done}); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b want=1", req_ready); end
      total++; if (wl_a.size() !== 1 || wl_a[0] !== 16'h1FFF || wl_d[0] !== 8'h77)
         begin bad++; $display("FAIL rst_mid_writes got n=%0d %h/%h want n=1 1fff/77", wl_a.size(), wl_a[0], wl_d[0]); end
      ack_lat = 0;
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_pop = 1'b0; req_tgt = 3'd0;
      rf_r16 = 16'h0; rf_a = 8'h0; rf_f = 4'h0; rf_pc = 16'h0; rf_sp = 16'h0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      #12;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      test_push_bc();
      test_pop_af();
      test_wrap_pc();
      test_wait_states();
      test_operand_latch();
      test_pop_de();
      test_back_to_back_af();
      test_illegal();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
